fpcvt_serial: RTL and testbench
===============================

FPCVT_SERIAL -- requirements
Module: fpcvt_serial

Interface
REQ-001 Parameter SIG_W, default 4, significand width.
REQ-002 Parameter EXP_W, default 3, exponent width.
REQ-003 Parameter IN_W, default 12, input width; SHALL equal SIG_W + 2**EXP_W; any other value is an elaboration error.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 D  input  IN_W  two's-complement sample.
REQ-007 in_valid  input  1  D valid; in_ready  output  1  block can accept.
REQ-008 S  output  1  sign; E  output  EXP_W  exponent; F  output  SIG_W  significand.
REQ-009 out_valid  output  1  S/E/F valid; out_ready  input  1  consumer accepts.

Function
REQ-010 FSM states: IDLE, NORM, ROUND, DONE; in_ready SHALL be high only in IDLE.
REQ-011 IDLE, in_valid high: accept on that edge, capture S = D[IN_W-1] and magnitude |D|, load exponent counter to 2**EXP_W-1, go to NORM.
REQ-012 D = most-negative value: S=1, magnitude SHALL saturate to 2**(IN_W-1)-1.
REQ-013 NORM, per cycle: if mag[IN_W-2]=1 or exponent=0, go to ROUND; else shift mag left 1 and decrement exponent.
REQ-014 ROUND: F0 = mag[IN_W-2 -: SIG_W], round bit R = mag[IN_W-2-SIG_W]; increment per REQ-022/023.
REQ-015 Increment with F0 all-ones: F = 1 followed by zeros, E+1; if E already 2**EXP_W-1, saturate F all-ones, E max.
REQ-016 ROUND -> DONE: register S/E/F and assert out_valid.
REQ-017 DONE: hold S/E/F/out_valid stable while out_ready low; out_ready high -> IDLE, out_valid deasserts next cycle.
REQ-018 No accept in the cycle a result retires; next accept at earliest one cycle later.
REQ-019 Latency: with k shifts, out_valid rises k+2 edges after accept edge; min 2, max 2**EXP_W+1.
REQ-020 Zero input: S=0, E=0, F=0 after k=2**EXP_W-1 shifts.
REQ-021 in_valid outside IDLE ignored; D need not be held after accept.

Configuration
REQ-022 Macro FPCVT_STICKY_EN defined: round-to-nearest-even; sticky T = OR of mag bits below R; increment iff R & (T | F0[0]).
REQ-023 FPCVT_STICKY_EN undefined: round-half-up; increment iff R; no sticky logic synthesised.

Reset
REQ-024 rst high: state IDLE, out_valid=0, S=0, E=0, F=0, internal mag/exponent cleared; in_ready=1 once rst low.
REQ-025 rst asserted in NORM/ROUND/DONE SHALL abort the conversion with no partial result ever presented.

Structure
REQ-026 Package fpcvt_pkg SHALL hold the state enum typedef and default-parameter constants.
REQ-027 Combinational rounder SHALL be sub-module fpcvt_round (inputs F0, R, T, E; outputs F, E), used in ROUND.
REQ-028 Target 120-400 lines RTL; no multipliers, no priority-encoder normaliser (serial shift only).

Verification (defaults)
REQ-029 D=422 (0x1A6) -> S=0, E=5, F=1101, out_valid 4 edges after accept.
REQ-030 D=-422 (0xE5A) -> S=1, E=5, F=1101; D=0x800 -> S=1, E=7, F=1111.
REQ-031 D=42 -> E=2, F=1011 without FPCVT_STICKY_EN; E=2, F=1010 with it.
REQ-032 D=125 -> E=4, F=1000 (significand overflow); D=2047 -> E=7, F=1111 (saturation).
REQ-033 D=0 -> E=0, F=0 at 9 edges; out_ready low 5 cycles -> outputs stable, in_ready low, then one-cycle retire.
REQ-034 rst pulse during NORM of D=422 -> out_valid stays 0, in_ready high after release; next D=46 -> E=2, F=1100.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg -- shared definitions for the serial integer-to-float converter.
//
// Contents:
//   state_t      : converter FSM states (IDLE, NORM, ROUND, DONE)
//   *_DEF        : default widths for significand, exponent and input sample
package fpcvt_pkg;

    localparam int SIG_W_DEF = 4;
    localparam int EXP_W_DEF = 3;
    localparam int IN_W_DEF  = SIG_W_DEF + (1 << EXP_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fpcvt_round.sv
// fpcvt_round -- combinational rounder for the serial converter.
//
// Build option: FPCVT_STICKY_EN
//   defined   : round-to-nearest-even, increment iff r & (t | f0[0])
//   undefined : round-half-up, increment iff r (t is ignored)
//
// Ports:
//   f0  in  SIG_W  truncated significand
//   r   in  1      round bit (first bit below f0)
//   t   in  1      sticky bit (OR of all bits below r)
//   e0  in  EXP_W  exponent before rounding
//   f   out SIG_W  rounded significand
//   e   out EXP_W  exponent after rounding
module fpcvt_round
    import fpcvt_pkg::*;
#(
    parameter int SIG_W = SIG_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic [SIG_W-1:0] f0,
    input  logic             r,
    input  logic             t,
    input  logic [EXP_W-1:0] e0,
    output logic [SIG_W-1:0] f,
    output logic [EXP_W-1:0] e
);

    logic inc;

`ifdef FPCVT_STICKY_EN
    assign inc = r & (t | f0[0]);
`else
    logic unused_t;
    assign unused_t = t;
    assign inc      = r;
`endif

    always_comb begin
        f = f0;
        e = e0;
        if (inc) begin
            if (&f0) begin
                // Significand overflow: renormalise by bumping the exponent,
                // or clamp to the largest representable value at max exponent.
                if (&e0) begin
                    f = '1;
                    e = '1;
                end else begin
                    f = {1'b1, {(SIG_W-1){1'b0}}};
                    e = e0 + 1'b1;
                end
            end else begin
                f = f0 + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpcvt_serial.sv
// fpcvt_serial -- serial two's-complement to sign/exponent/significand
// converter. The magnitude is normalised by shifting left one bit per cycle
// (no priority encoder), then rounded to SIG_W bits.
//
// Build option: FPCVT_STICKY_EN selects round-to-nearest-even (defined) or
// round-half-up (undefined, no sticky logic).
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   D          in   IN_W   two's-complement sample
//   in_valid   in   D valid
//   in_ready   out  converter idle, can accept
//   S          out  sign
//   E          out  EXP_W  exponent
//   F          out  SIG_W  significand
//   out_valid  out  S/E/F valid
//   out_ready  in   consumer accepts result
module fpcvt_serial
    import fpcvt_pkg::*;
#(
    parameter int SIG_W = SIG_W_DEF,
    parameter int EXP_W = EXP_W_DEF,
    parameter int IN_W  = IN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  D,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             S,
    output logic [EXP_W-1:0] E,
    output logic [SIG_W-1:0] F,
    output logic             out_valid,
    input  logic             out_ready
);

    generate
        if (IN_W != SIG_W + (1 << EXP_W)) begin : g_bad_width
            $error("fpcvt_serial: IN_W must equal SIG_W + 2**EXP_W");
        end
    endgenerate

    localparam int MAG_W = IN_W - 1;

    state_t             state_reg;
    logic               sign_reg;
    logic [MAG_W-1:0]   mag_reg;
    logic [EXP_W-1:0]   exp_reg;
    logic               s_reg;
    logic [EXP_W-1:0]   e_reg;
    logic [SIG_W-1:0]   f_reg;
    logic               out_valid_reg;

    logic [MAG_W-1:0]   mag_abs;
    logic               sticky;
    logic [SIG_W-1:0]   f_rnd;
    logic [EXP_W-1:0]   e_rnd;

    // |D| on MAG_W bits. The low bits of -D depend only on the low bits of D,
    // so negation is done at MAG_W width. The most-negative value has no
    // positive counterpart and saturates to all-ones.
    always_comb begin
        mag_abs = D[MAG_W-1:0];
        if (D[IN_W-1]) begin
            if (D[MAG_W-1:0] == '0) begin
                mag_abs = '1;
            end else begin
                mag_abs = ~D[MAG_W-1:0] + 1'b1;
            end
        end
    end

`ifdef FPCVT_STICKY_EN
    assign sticky = |mag_reg[MAG_W-2-SIG_W:0];
`else
    logic unused_mag_low;
    assign unused_mag_low = |mag_reg[MAG_W-2-SIG_W:0];
    assign sticky         = 1'b0;
`endif

    fpcvt_round #(
        .SIG_W (SIG_W),
        .EXP_W (EXP_W)
    ) u_round (
        .f0 (mag_reg[MAG_W-1 -: SIG_W]),
        .r  (mag_reg[MAG_W-1-SIG_W]),
        .t  (sticky),
        .e0 (exp_reg),
        .f  (f_rnd),
        .e  (e_rnd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            sign_reg      <= 1'b0;
            mag_reg       <= '0;
            exp_reg       <= '0;
            s_reg         <= 1'b0;
            e_reg         <= '0;
            f_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_reg  <= D[IN_W-1];
                        mag_reg   <= mag_abs;
                        exp_reg   <= '1;
                        state_reg <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    // Stop once the leading one reaches the top, or when the
                    // exponent bottoms out (zero or very small inputs).
                    if (mag_reg[MAG_W-1] || (exp_reg == '0)) begin
                        state_reg <= ST_ROUND;
                    end else begin
                        mag_reg <= mag_reg << 1;
                        exp_reg <= exp_reg - 1'b1;
                    end
                end
                ST_ROUND: begin
                    s_reg         <= sign_reg;
                    e_reg         <= e_rnd;
                    f_reg         <= f_rnd;
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign S         = s_reg;
    assign E         = e_reg;
    assign F         = f_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_fpcvt_serial.sv
// tb_fpcvt_serial -- directed self-checking bench for fpcvt_serial with a
// scoreboard queue of expected results.
module tb_fpcvt_serial;

    logic        clk;
    logic        rst;
    logic [11:0] D;
    logic        in_valid;
    logic        in_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        out_valid;
    logic        out_ready;

    typedef struct {
        logic       s;
        logic [2:0] e;
        logic [3:0] f;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    fpcvt_serial dut (
        .clk       (clk),
        .rst       (rst),
        .D         (D),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One full transaction: accept d, wait for the result, optionally stall
    // the consumer for 'hold' cycles, then retire.
    task automatic convert(input logic [11:0] d, input logic s, input logic [2:0] e,
                           input logic [3:0] f, input int lat, input int hold,
                           input string tag);
        exp_t x;
        exp_t got;
        int   n;
        check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
        D        = d;
        in_valid = 1'b1;
        x.s = s; x.e = e; x.f = f; x.lat = lat;
        sb.push_back(x);
        @(posedge clk); #1;
        // Junk while busy must be ignored.
        D = 12'h7FF;
        check({tag, " busy"}, {31'd0, in_ready}, 32'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        got = sb.pop_front();
        check({tag, " latency"}, n, got.lat);
        check({tag, " S"}, {31'd0, S}, {31'd0, got.s});
        check({tag, " E"}, {29'd0, E}, {29'd0, got.e});
        check({tag, " F"}, {28'd0, F}, {28'd0, got.f});
        $display("txn %s: D=%03h -> S=%0b E=%0d F=%04b after %0d edges", tag, d, S, E, F, n);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, " hold ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, " hold SEF"}, {24'd0, S, E, F}, {24'd0, got.s, got.e, got.f});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, " retire valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " retire idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        D         = 12'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", {31'd0, out_valid}, 32'd0);
        check("reset SEF", {24'd0, S, E, F}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset ready", {31'd0, in_ready}, 32'd1);

        convert(12'h1A6, 1'b0, 3'd5, 4'b1101, 4, 0, "p422");
        convert(12'hE5A, 1'b1, 3'd5, 4'b1101, 4, 0, "n422");
        convert(12'h800, 1'b1, 3'd7, 4'b1111, 2, 0, "minneg");
`ifdef FPCVT_STICKY_EN
        convert(12'd42, 1'b0, 3'd2, 4'b1010, 7, 0, "p42");
`else
        convert(12'd42, 1'b0, 3'd2, 4'b1011, 7, 0, "p42");
`endif
        convert(12'd125, 1'b0, 3'd4, 4'b1000, 6, 0, "p125");
        convert(12'd2047, 1'b0, 3'd7, 4'b1111, 2, 0, "p2047");
        convert(12'd1024, 1'b0, 3'd7, 4'b1000, 2, 0, "p1024");
        convert(12'd1, 1'b0, 3'd0, 4'b0001, 9, 0, "p1");
        convert(12'hFFF, 1'b1, 3'd0, 4'b0001, 9, 0, "n1");
        convert(12'd0, 1'b0, 3'd0, 4'b0000, 9, 5, "zero");

        // Reset in the middle of normalisation must abort silently.
        D        = 12'h1A6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort valid", {31'd0, out_valid}, 32'd0);
        check("abort ready", {31'd0, in_ready}, 32'd1);
        check("abort SEF", {24'd0, S, E, F}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("abort quiet", {30'd0, out_valid, in_ready}, 32'd1);
        end
        $display("txn abort: reset during NORM, no result presented");

`ifdef FPCVT_STICKY_EN
        convert(12'd46, 1'b0, 3'd2, 4'b1100, 7, 0, "p46");
`else
        convert(12'd46, 1'b0, 3'd2, 4'b1100, 7, 0, "p46");
`endif

        check("sb empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
